// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit.
//   FWD_*  : forwarding select encodings driven on Forward_E
//   ST_*   : 2-bit codes of the memory-freeze FSM states
//   state_t: enum built on those codes
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;   // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;   // operand from W-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;   // operand from M-stage result

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        WAIT    = ST_WAIT,
        RELEASE = ST_RELEASE
    } state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of all pipeline <-> hazard-unit signals.
//   master: pipeline side, drives stage info, receives stall/flush/forward
//   slave : hazard unit side
// Signals: RegWriteM/W, ResultSrcE0, MemReadM, PCSrcE, RD_E/M/W, Rs_D, Rs_E
// (operand i at [i*REG_ADDR_W +: REG_ADDR_W]), Forward_E (operand i at
// [2i +: 2]), Stall{F,D,E,M}, Flush{D,E,W}, perf_stall_cnt, perf_flush_cnt.
interface hazard_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2
);
    logic                          RegWriteM;
    logic                          RegWriteW;
    logic                          ResultSrcE0;
    logic                          MemReadM;
    logic                          PCSrcE;
    logic [REG_ADDR_W-1:0]         RD_E;
    logic [REG_ADDR_W-1:0]         RD_M;
    logic [REG_ADDR_W-1:0]         RD_W;
    logic [NUM_SRC*REG_ADDR_W-1:0] Rs_D;
    logic [NUM_SRC*REG_ADDR_W-1:0] Rs_E;
    logic [NUM_SRC*2-1:0]          Forward_E;
    logic                          StallF;
    logic                          StallD;
    logic                          StallE;
    logic                          StallM;
    logic                          FlushD;
    logic                          FlushE;
    logic                          FlushW;
    logic [31:0]                   perf_stall_cnt;
    logic [31:0]                   perf_flush_cnt;

    modport master (
        output RegWriteM, RegWriteW, ResultSrcE0, MemReadM, PCSrcE,
               RD_E, RD_M, RD_W, Rs_D, Rs_E,
        input  Forward_E, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  RegWriteM, RegWriteW, ResultSrcE0, MemReadM, PCSrcE,
               RD_E, RD_M, RD_W, Rs_D, Rs_E,
        output Forward_E, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// fwd_sel: forwarding select for one E-stage source operand.
//   RegWriteM, RD_M : M-stage writer (highest priority, the youngest value)
//   RegWriteW, RD_W : W-stage writer
//   Rs              : E-stage source register index
//   sel             : FWD_MEM / FWD_WB / FWD_RF
// x0 is never forwarded since writes to it are discarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [REG_ADDR_W-1:0] RD_W,
    input  logic [REG_ADDR_W-1:0] Rs,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_RF;
        if (RegWriteM && (RD_M != '0) && (RD_M == Rs)) begin
            sel = FWD_MEM;
        end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding, load-use stall, branch flush and
// multi-cycle data-memory freeze for the 5-stage RISC-V pipeline.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low; while low every output is 0
//   bus  : hazard_ctrl_unit_if.slave (stage info in, stall/flush/forward out)
// Optional feature macro HAZARD_PERF_CNT_EN: when defined, perf_stall_cnt
// counts cycles with any stall and perf_flush_cnt counts cycles with FlushD;
// when undefined both read 0 and no counter flops exist.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DMEM_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_unit_if.slave bus
);

    // At least one bit so DMEM_LAT=0 still elaborates.
    localparam int CNT_W = (DMEM_LAT > 0) ? $clog2(DMEM_LAT + 1) : 1;

    logic [NUM_SRC*2-1:0] fwd_raw;
    logic                 lu;
    logic                 lu_match;
    logic                 mem_stall;
    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_sel (
            .RegWriteM (bus.RegWriteM),
            .RegWriteW (bus.RegWriteW),
            .RD_M      (bus.RD_M),
            .RD_W      (bus.RD_W),
            .Rs        (bus.Rs_E[i*REG_ADDR_W +: REG_ADDR_W]),
            .sel       (fwd_raw[2*i +: 2])
        );
    end

    always_comb begin
        lu_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.RD_E == bus.Rs_D[i*REG_ADDR_W +: REG_ADDR_W]) begin
                lu_match = 1'b1;
            end
        end
        lu = bus.ResultSrcE0 && (bus.RD_E != '0) && lu_match;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The freeze is asserted combinationally in the cycle the load is seen,
    // so cnt holds the number of freeze cycles still to come after this one.
    // RELEASE skips one cycle of MemReadM: it is the same load moving on.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.MemReadM && (DMEM_LAT > 0)) begin
                    mem_stall  = 1'b1;
                    cnt_next   = CNT_W'(DMEM_LAT - 1);
                    state_next = (DMEM_LAT == 1) ? RELEASE : WAIT;
                end
            end
            WAIT: begin
                mem_stall  = 1'b1;
                cnt_next   = cnt - CNT_W'(1);
                state_next = (cnt == CNT_W'(1)) ? RELEASE : WAIT;
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Freeze dominates and holds any pending branch/load-use until it ends;
    // a taken branch squashes the load-use candidate in D.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (bus.PCSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign bus.Forward_E = rst ? fwd_raw : '0;
    assign bus.StallF    = stall_f;
    assign bus.StallD    = stall_d;
    assign bus.StallE    = stall_e;
    assign bus.StallM    = stall_m;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;
    assign bus.FlushW    = flush_w;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f || stall_d || stall_e || stall_m) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_d) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = rst ? stall_cnt : '0;
    assign bus.perf_flush_cnt = rst ? flush_cnt : '0;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif

endmodule
